// File: rtl/vliw_wb_merge.sv
// Writeback merge buffer: queues lane register writes in program order, drains
// them through WPORTS register-file write ports, and forwards pending data to lookups.
module vliw_wb_merge #(
  parameter int XLEN   = 64,
  parameter int LANES  = 4,
  parameter int WPORTS = 2,
  parameter int DEPTH  = 8,
  parameter int NRD    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              LaneWE,
  input  logic [LANES*5-1:0]            LaneRd,
  input  logic [LANES*XLEN-1:0]         LaneWD,
  output logic [WPORTS-1:0]             RfWE,
  output logic [WPORTS*5-1:0]           RfA,
  output logic [WPORTS*XLEN-1:0]        RfWD,
  input  logic [NRD*5-1:0]              LkA,
  output logic [NRD-1:0]                LkHit,
  output logic [NRD*XLEN-1:0]           LkData,
  output logic                          StallWBD,
  output logic                          Overflow,
  output logic [$clog2(DEPTH+1)-1:0]    Count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]      mem_rd [DEPTH];
  logic [XLEN-1:0] mem_wd [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [31:0]     cnt32, k, space, n_acc, n_surv;
  logic [LANES-1:0] surv, acc;
  logic [PW-1:0]   slot [LANES];

  assign cnt32    = 32'(Count);
  assign k        = (cnt32 < 32'(WPORTS)) ? cnt32 : 32'(WPORTS);
  assign space    = 32'(DEPTH) - cnt32 + k;
  assign StallWBD = cnt32 > 32'(DEPTH - LANES);

  // Filter the bundle, then pack accepted survivors into consecutive tail slots.
  always_comb begin
    surv   = '0;
    acc    = '0;
    n_acc  = '0;
    n_surv = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = '0;
      surv[i] = LaneWE[i] && (LaneRd[5*i +: 5] != 5'd0);
      for (int j = i + 1; j < LANES; j++)
        if (LaneWE[j] && (LaneRd[5*j +: 5] == LaneRd[5*i +: 5]))
          surv[i] = 1'b0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (surv[i]) begin
        n_surv = n_surv + 32'd1;
        if (n_acc < space) begin
          acc[i]  = 1'b1;
          slot[i] = tail + n_acc[PW-1:0];
          n_acc   = n_acc + 32'd1;
        end
      end
    end
  end

  // An older drained entry is suppressed when a younger drained one targets the same rd.
  always_comb begin
    RfWE = '0;
    RfA  = '0;
    RfWD = '0;
    for (int j = 0; j < WPORTS; j++) begin
      RfA[5*j +: 5]       = mem_rd[head + PW'(j)];
      RfWD[XLEN*j +: XLEN] = mem_wd[head + PW'(j)];
      RfWE[j]             = 32'(j) < cnt32;
      for (int m = j + 1; m < WPORTS; m++)
        if ((32'(m) < cnt32) && (mem_rd[head + PW'(m)] == mem_rd[head + PW'(j)]))
          RfWE[j] = 1'b0;
    end
  end

  // Scan oldest to youngest so the youngest match is the one that sticks.
  always_comb begin
    LkHit  = '0;
    LkData = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if ((LkA[5*p +: 5] != 5'd0) && (32'(e) < cnt32) &&
            (mem_rd[head + PW'(e)] == LkA[5*p +: 5])) begin
          LkHit[p]               = 1'b1;
          LkData[XLEN*p +: XLEN] = mem_wd[head + PW'(e)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      head  <= head + k[PW-1:0];
      tail  <= tail + n_acc[PW-1:0];
      Count <= CW'(cnt32 - k + n_acc);
      if (n_surv > n_acc)
        Overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (acc[i]) begin
        mem_rd[slot[i]] <= LaneRd[5*i +: 5];
        mem_wd[slot[i]] <= LaneWD[XLEN*i +: XLEN];
      end
    end
  end

endmodule

// File: doc/vliw_wb_merge.md
# vliw_wb_merge

Writeback merge buffer for the VLIW integer lanes. It accepts up to LANES register-write requests per cycle from the lane Writeback stages (each lane's we3/a3/wd3). It queues them in program order and drains them into the widened register file through WPORTS physical write ports. It also answers operand lookups for writes that are still pending, and it back-pressures the lanes with a stall when it is close to full.

## Interface
- XLEN, 64, register width
- LANES, 4, number of lane write requests per cycle
- WPORTS, 2, register-file write ports drained per cycle
- DEPTH, 8, queue entries; must be ≥ LANES and a power of two
- NRD, 8, number of lookup ports (2 per lane)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- LaneWE  in  LANES  per-lane write request
- LaneRd  in  LANES×5  per-lane destination register; lane i occupies bits [5i+4:5i]
- LaneWD  in  LANES×XLEN  per-lane write data
- RfWE  out  WPORTS  register-file write enables
- RfA  out  WPORTS×5  register-file write addresses
- RfWD  out  WPORTS×XLEN  register-file write data
- LkA  in  NRD×5  lookup register addresses
- LkHit  out  NRD  a pending write to LkA exists
- LkData  out  NRD×XLEN  data of the youngest pending write to LkA; 0 on miss
- StallWBD  out  1  lanes must not present new requests next cycle
- Overflow  out  1  sticky error: a request was lost to a full queue
- Count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- The queue is a circular buffer of {rd[4:0], data[XLEN-1:0]}, with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Enqueue filter, applied per cycle:
  - Drop requests with LaneWE=0 or LaneRd=0.
  - If two lanes in the same bundle name the same rd, the higher-indexed lane wins and the lower one is dropped.
- Surviving requests are written at consecutive tail slots in ascending lane order. Tail advances by the number of survivors.
- Drain: k = min(Count, WPORTS) oldest entries are presented on RfWE/RfA/RfWD port 0 onward. They are combinational from head, and head advances by k at the edge.
  - Port j with j ≥ Count has RfWE[j]=0.
  - If two drained entries share rd, the RfWE of the older one is forced to 0. It is still popped.
- Drain and enqueue in the same cycle:
  - Drain sees the pre-edge contents only.
  - Next Count = Count − k + survivors.
- Lookup is combinational over the currently occupied entries. It returns the youngest matching entry.
  - LkA=0 always misses.
  - Entries draining this cycle still hit.
  - Same-cycle lane requests are not visible to lookup.
- StallWBD = (Count > DEPTH − LANES), combinational from registered Count.
- Overflow: if the number of survivors exceeds DEPTH − Count + k, the excess highest-lane survivors are discarded and Overflow sets. It clears only on reset.
- Reset, asynchronous: head=tail=0, Count=0, Overflow=0, RfWE=0, LkHit=0, StallWBD=0. Entry storage needs no reset.

## Timing
- Minimum latency is 1 cycle. A request accepted at edge N appears on RfWE during cycle N+1 and is written to the register file at edge N+1.
- Throughput is WPORTS writes per cycle. A full bundle of LANES survivors with an empty queue takes ⌈LANES/WPORTS⌉ cycles to drain.
- StallWBD reflects Count after edge N. Lanes sample it in cycle N+1.
- Reset asserted mid-drain discards all pending entries immediately, with no further RfWE pulses. Deassertion is synchronized externally.
- Head and tail wrap from DEPTH−1 to 0 with no bubble. Full (Count=DEPTH) and empty (Count=0) are distinguished by Count, not by pointer equality.

## Test plan
- Reset, then a single write: lane 2 writes rd=5, data 0xAB. In the next cycle RfWE=01, RfA[0]=5, RfWD[0]=0xAB, and Count returns to 0 the cycle after.
- Full bundle with WPORTS=2: lanes 0–3 write rd=1..4. Cycle +1 writes rd 1,2; cycle +2 writes rd 3,4; StallWBD stays 0.
- Intra-bundle conflict: lanes 0 and 3 both write rd=7, with 0x11 and 0x22. Only 0x22 is enqueued and Count=1. A lookup of 7 returns LkHit=1, LkData=0x22.
- Back-pressure and wrap: issue full bundles ignoring StallWBD until Count=8. StallWBD rises once Count exceeds 4, and a further bundle sets Overflow=1. Keep draining past the pointer wrap and check FIFO order is preserved.
- Drained duplicate: enqueue rd=9 (0x1) and then rd=9 (0x2) as the two oldest entries. RfWE=10 and register 9 is left holding 0x2. LkA=0 and rd=0 requests never hit or enqueue.
- Asynchronous reset while Count=6: Count, RfWE and LkHit go to 0 immediately without waiting for a clock edge, and Overflow clears.
